// File: rtl/seven_seg_display_ctrl.sv
// ----------------------------------------------------------------------------
// seven_seg_display_ctrl
//
// Sequencing controller for the three-digit seven-segment scanner in the GPIO block.
// A 12-bit value is accepted over a valid/ready handshake. In decimal mode it is converted
// to BCD by a sequential double-dabble engine (one shift per cycle); in hex mode the
// nibbles are used directly. Each digit is encoded to an active-high segment byte
// (bit0..bit6 = a..g, bit7 = dp) and the three bytes are committed together into
// threeDigits, so the scanner never sees a partially built word.
//
// Optional feature (compile-time macro SEVEN_SEG_LEADING_ZERO_BLANK_EN):
//   defined   - in decimal mode a zero hundreds digit is blanked, and a zero tens digit is
//               blanked too when hundreds is blanked. Units is never blanked.
//   undefined - leading zeros are shown as '0'. Hex mode is never blanked.
//
// Ports:
//   clock          in   1   system clock
//   reset          in   1   synchronous, active-low reset
//   valueIn        in   12  value to display, sampled on accept
//   valueValid     in   1   request strobe; accepted when valueValid && ready
//   hexMode        in   1   sampled on accept: 1 = hex, 0 = decimal
//   decimalPoints  in   3   sampled on accept: bit2/1/0 = dp of hundreds/tens/units
//   ready          out  1   controller idle
//   threeDigits    out  24  [23:16] hundreds, [15:8] tens, [7:0] units
//   overflow       out  1   last accepted decimal value exceeded 999
// ----------------------------------------------------------------------------
module seven_seg_display_ctrl #(
  parameter int unsigned CONV_BITS  = 12,
  parameter logic [7:0]  BLANK_CODE = 8'h00,
  parameter logic [7:0]  DASH_CODE  = 8'h40
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [CONV_BITS-1:0] valueIn,
  input  logic                 valueValid,
  input  logic                 hexMode,
  input  logic [2:0]           decimalPoints,
  output logic                 ready,
  output logic [23:0]          threeDigits,
  output logic                 overflow
);

  typedef enum logic [1:0] {
    StIdle,
    StConvert,
    StEncode
  } state_e;

  localparam logic [3:0] LastCount = 4'(CONV_BITS - 1);

  state_e               state_q, state_d;
  logic [CONV_BITS-1:0] value_q, value_d;
  logic [11:0]          bcd_q, bcd_d;
  logic [3:0]           cnt_q, cnt_d;
  logic                 hex_q, hex_d;
  logic [2:0]           dp_q, dp_d;
  logic                 ovf_q, ovf_d;
  logic [23:0]          digits_q, digits_d;

  logic                 accept;
  logic                 value_too_big;
  logic [11:0]          bcd_adj;
  logic [3:0]           nib_h, nib_t, nib_u;
  logic                 blank_h, blank_t;
  logic [7:0]           byte_h, byte_t, byte_u;

  // Active-high segment pattern for one digit, dp bit clear.
  function automatic logic [7:0] seg_code(input logic [3:0] nib);
    logic [7:0] code;
    case (nib)
      4'h0:    code = 8'h3F;
      4'h1:    code = 8'h06;
      4'h2:    code = 8'h5B;
      4'h3:    code = 8'h4F;
      4'h4:    code = 8'h66;
      4'h5:    code = 8'h6D;
      4'h6:    code = 8'h7D;
      4'h7:    code = 8'h07;
      4'h8:    code = 8'h7F;
      4'h9:    code = 8'h6F;
      4'hA:    code = 8'h77;
      4'hB:    code = 8'h7C;
      4'hC:    code = 8'h39;
      4'hD:    code = 8'h5E;
      4'hE:    code = 8'h79;
      default: code = 8'h71;
    endcase
    return code;
  endfunction

  // Double-dabble correction: add 3 to each BCD nibble >= 5 before the shift.
  function automatic logic [3:0] dabble(input logic [3:0] nib);
    return (nib >= 4'd5) ? nib + 4'd3 : nib;
  endfunction

  assign ready         = (state_q == StIdle);
  assign accept        = valueValid && ready;
  assign value_too_big = 32'(valueIn) > 32'd999;

  assign bcd_adj = {dabble(bcd_q[11:8]), dabble(bcd_q[7:4]), dabble(bcd_q[3:0])};

  // Hex digits come straight from the latched value, which is only shifted in decimal mode.
  assign nib_h = hex_q ? value_q[11:8] : bcd_q[11:8];
  assign nib_t = hex_q ? value_q[7:4]  : bcd_q[7:4];
  assign nib_u = hex_q ? value_q[3:0]  : bcd_q[3:0];

`ifdef SEVEN_SEG_LEADING_ZERO_BLANK_EN
  assign blank_h = !hex_q && (nib_h == 4'd0);
  assign blank_t = blank_h && (nib_t == 4'd0);
`else
  assign blank_h = 1'b0;
  assign blank_t = 1'b0;
`endif

  // Overflow replaces every digit with a dash; dp bits are still applied on top.
  always_comb begin
    byte_h = 8'h00;
    byte_t = 8'h00;
    byte_u = 8'h00;
    if (ovf_q) begin
      byte_h = DASH_CODE;
      byte_t = DASH_CODE;
      byte_u = DASH_CODE;
    end else begin
      byte_h = blank_h ? BLANK_CODE : seg_code(nib_h);
      byte_t = blank_t ? BLANK_CODE : seg_code(nib_t);
      byte_u = seg_code(nib_u);
    end
    byte_h = byte_h | {dp_q[2], 7'b0};
    byte_t = byte_t | {dp_q[1], 7'b0};
    byte_u = byte_u | {dp_q[0], 7'b0};
  end

  always_comb begin
    state_d  = state_q;
    value_d  = value_q;
    bcd_d    = bcd_q;
    cnt_d    = cnt_q;
    hex_d    = hex_q;
    dp_d     = dp_q;
    ovf_d    = ovf_q;
    digits_d = digits_q;

    unique case (state_q)
      StIdle: begin
        if (accept) begin
          value_d = valueIn;
          hex_d   = hexMode;
          dp_d    = decimalPoints;
          ovf_d   = !hexMode && value_too_big;
          bcd_d   = 12'd0;
          cnt_d   = 4'd0;
          state_d = (!hexMode && !value_too_big) ? StConvert : StEncode;
        end
      end

      StConvert: begin
        // Shift {bcd, value} left by one after the per-nibble correction.
        bcd_d   = {bcd_adj[10:0], value_q[CONV_BITS-1]};
        value_d = {value_q[CONV_BITS-2:0], 1'b0};
        cnt_d   = cnt_q + 4'd1;
        if (cnt_q == LastCount) begin
          state_d = StEncode;
        end
      end

      StEncode: begin
        digits_d = {byte_h, byte_t, byte_u};
        state_d  = StIdle;
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q  <= StIdle;
      value_q  <= '0;
      bcd_q    <= 12'd0;
      cnt_q    <= 4'd0;
      hex_q    <= 1'b0;
      dp_q     <= 3'd0;
      ovf_q    <= 1'b0;
      digits_q <= 24'd0;
    end else begin
      state_q  <= state_d;
      value_q  <= value_d;
      bcd_q    <= bcd_d;
      cnt_q    <= cnt_d;
      hex_q    <= hex_d;
      dp_q     <= dp_d;
      ovf_q    <= ovf_d;
      digits_q <= digits_d;
    end
  end

  assign threeDigits = digits_q;
  assign overflow    = ovf_q;

endmodule

// File: tb/tb_seven_seg_display_ctrl.sv
// ----------------------------------------------------------------------------
// tb_seven_seg_display_ctrl
//
// Directed bench for seven_seg_display_ctrl. Each request pushes its expected display
// word, overflow flag and latency to a scoreboard; the entry is popped and compared
// when ready returns high. Inputs are driven and outputs sampled on the falling edge.
// ----------------------------------------------------------------------------
module tb_seven_seg_display_ctrl;

`ifdef SEVEN_SEG_LEADING_ZERO_BLANK_EN
  localparam bit Zb = 1'b1;
`else
  localparam bit Zb = 1'b0;
`endif

  logic        clock;
  logic        reset;
  logic [11:0] valueIn;
  logic        valueValid;
  logic        hexMode;
  logic [2:0]  decimalPoints;
  logic        ready;
  logic [23:0] threeDigits;
  logic        overflow;

  int          n_cmp;
  int          n_fail;
  logic [24:0] exp_q[$];
  int          lat_q[$];
  logic [23:0] cur_digits;

  seven_seg_display_ctrl dut (
    .clock         (clock),
    .reset         (reset),
    .valueIn       (valueIn),
    .valueValid    (valueValid),
    .hexMode       (hexMode),
    .decimalPoints (decimalPoints),
    .ready         (ready),
    .threeDigits   (threeDigits),
    .overflow      (overflow)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [23:0] obs, input logic [23:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Issue one request from the falling edge before accept edge T; m counts falling edges
  // after T. poke_at / rst_at (>0) pulse valueValid / reset so they are sampled at T+n.
  task automatic send(input string tag, input logic [11:0] v, input logic hx,
                      input logic [2:0] dp, input logic [23:0] exp_d, input logic exp_o,
                      input int lat, input int poke_at, input int rst_at);
    logic [24:0] e;
    int          l;
    int          m;
    exp_q.push_back({exp_o, exp_d});
    lat_q.push_back(lat);
    check({tag, "_ready_before"}, {23'd0, ready}, 24'd1);
    valueIn       = v;
    hexMode       = hx;
    decimalPoints = dp;
    valueValid    = 1'b1;
    @(negedge clock);
    valueValid    = 1'b0;
    valueIn       = 12'($urandom);
    hexMode       = 1'($urandom);
    decimalPoints = 3'($urandom);
    m = 0;
    check({tag, "_busy"}, {23'd0, ready}, 24'd0);
    while (ready !== 1'b1 && m < 40) begin
      if (m == lat - 1) check({tag, "_hold"}, threeDigits, cur_digits);
      if (m == poke_at - 1) begin
        valueValid = 1'b1;
        valueIn    = 12'd7;
        hexMode    = 1'b0;
      end
      if (m == rst_at - 1) reset = 1'b0;
      @(negedge clock);
      m++;
      valueValid = 1'b0;
      reset      = 1'b1;
    end
    e = exp_q.pop_front();
    l = lat_q.pop_front();
    check({tag, "_latency"}, 24'(m), 24'(l));
    check({tag, "_digits"}, threeDigits, e[23:0]);
    check({tag, "_overflow"}, {23'd0, overflow}, {23'd0, e[24]});
    cur_digits = e[23:0];
  endtask

  initial begin
    n_cmp         = 0;
    n_fail        = 0;
    cur_digits    = 24'd0;
    reset         = 1'b0;
    valueIn       = 12'd0;
    valueValid    = 1'b0;
    hexMode       = 1'b0;
    decimalPoints = 3'd0;

    repeat (2) @(negedge clock);
    check("reset_ready", {23'd0, ready}, 24'd1);
    check("reset_digits", threeDigits, 24'h000000);
    check("reset_overflow", {23'd0, overflow}, 24'd0);
    reset = 1'b1;
    @(negedge clock);
    check("idle_digits", threeDigits, 24'h000000);

    send("dec123", 12'd123, 1'b0, 3'b000, 24'h065B4F, 1'b0, 13, -1, -1);
    send("hexABC", 12'hABC, 1'b1, 3'b000, 24'h777C39, 1'b0, 1, -1, -1);
    send("ovf1000", 12'd1000, 1'b0, 3'b010, 24'h40C040, 1'b1, 1, -1, -1);
    send("dec5", 12'd5, 1'b0, 3'b000, Zb ? 24'h00006D : 24'h3F3F6D, 1'b0, 13, -1, -1);

    // Request pulsed while busy must be dropped, not queued.
    send("dec999", 12'd999, 1'b0, 3'b000, 24'h6F6F6F, 1'b0, 13, 5, -1);
    repeat (4) @(negedge clock);
    check("busy_drop_digits", threeDigits, 24'h6F6F6F);
    check("busy_drop_ready", {23'd0, ready}, 24'd1);

    // Reset sampled at T+6 aborts the conversion.
    send("rst456", 12'd456, 1'b0, 3'b000, 24'h000000, 1'b0, 6, -1, 6);
    repeat (15) @(negedge clock);
    check("rst_after_digits", threeDigits, 24'h000000);
    check("rst_after_ready", {23'd0, ready}, 24'd1);
    check("rst_after_overflow", {23'd0, overflow}, 24'd0);

    send("hex001", 12'h001, 1'b1, 3'b000, 24'h3F3F06, 1'b0, 1, -1, -1);
    send("hex002", 12'h002, 1'b1, 3'b000, 24'h3F3F5B, 1'b0, 1, -1, -1);
    send("dec0dp", 12'd0, 1'b0, 3'b111, Zb ? 24'h8080BF : 24'hBFBFBF, 1'b0, 13, -1, -1);
    send("dec060", 12'd60, 1'b0, 3'b000, Zb ? 24'h007D3F : 24'h3F7D3F, 1'b0, 13, -1, -1);
    send("dec205", 12'd205, 1'b0, 3'b000, 24'h5B3F6D, 1'b0, 13, -1, -1);
    send("ovf4095", 12'd4095, 1'b0, 3'b101, 24'hC040C0, 1'b1, 1, -1, -1);
    send("hexFFF", 12'hFFF, 1'b1, 3'b001, 24'h7171F1, 1'b0, 1, -1, -1);
    send("hex000", 12'h000, 1'b1, 3'b000, 24'h3F3F3F, 1'b0, 1, -1, -1);
    send("dec780", 12'd780, 1'b0, 3'b100, 24'h877F3F, 1'b0, 13, -1, -1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
